// File: rtl/jtag_dr_bridge.sv
// rtl/jtag_dr_bridge.sv - multi-channel JTAGG user-DR bridge into the system clock domain
// Synchronises JTAGG strobes, captures/shifts/updates a DR and hands committed words to the SoC.
module jtag_dr_bridge #(
    parameter int DR_WIDTH    = 32,
    parameter int NUM_CH      = 2,
    parameter int SYNC_STAGES = 2,
    localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       jtck,
    input  logic                       jtdi,
    input  logic                       jshift,
    input  logic                       jupdate,
    input  logic [NUM_CH-1:0]          jce,
    input  logic                       jrstn,
    output logic [NUM_CH-1:0]          jtdo,
    input  logic [NUM_CH*DR_WIDTH-1:0] dr_in,
    output logic [DR_WIDTH-1:0]        dr_out,
    output logic [SEL_W-1:0]           dr_sel,
    output logic                       dr_valid,
    input  logic                       dr_ready,
    output logic                       dr_short,
    output logic                       dr_overrun,
    input  logic                       ovr_clr
);

    localparam int NSYNC = NUM_CH + 5;
    localparam int CNT_W = $clog2(DR_WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DR_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        COMMIT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0][NSYNC-1:0] sync_q;
    logic [NSYNC-1:0]  sync_out;
    logic              tck_s, jtdi_s, jshift_s, jupdate_s, jrstn_s;
    logic [NUM_CH-1:0] jce_s;
    logic              tck_d1, tck_d2, tck_rise;

    state_t               state;
    logic [DR_WIDTH-1:0]  shreg;
    logic [CNT_W-1:0]     bitcnt;
    logic [SEL_W-1:0]     sel;
    logic [SEL_W-1:0]     next_sel;
    logic                 shift_q;

    function automatic logic [SEL_W-1:0] first_ch(input logic [NUM_CH-1:0] m);
        first_ch = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (m[k]) first_ch = SEL_W'(k);
        end
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
            tck_d1 <= 1'b0;
            tck_d2 <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {jce, jrstn, jupdate, jshift, jtdi, jtck}};
            tck_d1 <= tck_s;
            tck_d2 <= tck_d1;
        end
    end

    assign sync_out  = sync_q[SYNC_STAGES-1];
    assign tck_s     = sync_out[0];
    assign jtdi_s    = sync_out[1];
    assign jshift_s  = sync_out[2];
    assign jupdate_s = sync_out[3];
    assign jrstn_s   = sync_out[4];
    assign jce_s     = sync_out[5 +: NUM_CH];

    // Edge taken one clk after the synchronised tck so the data lines have settled.
    assign tck_rise = tck_d1 & ~tck_d2;

    always_comb begin
        next_sel = first_ch(jce_s);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            shreg      <= '0;
            bitcnt     <= '0;
            sel        <= '0;
            shift_q    <= 1'b0;
            jtdo       <= '0;
            dr_out     <= '0;
            dr_sel     <= '0;
            dr_valid   <= 1'b0;
            dr_short   <= 1'b0;
            dr_overrun <= 1'b0;
        end else begin
            if (dr_valid && dr_ready) dr_valid <= 1'b0;
            if (ovr_clr) dr_overrun <= 1'b0;
            jtdo <= '0;
            if (state != IDLE) jtdo[sel] <= shreg[0];

            if (!jrstn_s) begin
                state   <= IDLE;
                shreg   <= '0;
                bitcnt  <= '0;
                shift_q <= 1'b0;
                jtdo    <= '0;
            end else begin
                if (tck_rise) shift_q <= jshift_s;
                case (state)
                    IDLE: begin
                        if (tck_rise && (jce_s != '0)) begin
                            sel    <= next_sel;
                            shreg  <= dr_in[int'(next_sel) * DR_WIDTH +: DR_WIDTH];
                            bitcnt <= '0;
                            state  <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        if (tck_rise) begin
                            if (shift_q) begin
                                shreg <= {jtdi_s, shreg[DR_WIDTH-1:1]};
                                if (bitcnt != CNT_MAX) bitcnt <= bitcnt + 1'b1;
                            end
                            if (jupdate_s) state <= COMMIT;
                            else if ((jce_s == '0) && !shift_q) state <= IDLE;
                        end
                    end
                    COMMIT: begin
                        // A commit beats a same-cycle handshake and wins over ovr_clr.
                        dr_out   <= shreg;
                        dr_sel   <= sel;
                        dr_short <= (bitcnt != CNT_W'(DR_WIDTH));
                        if (dr_valid && !dr_ready) dr_overrun <= 1'b1;
                        dr_valid <= 1'b1;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtag_dr_bridge.sv
// tb/tb_jtag_dr_bridge.sv - randomized self-checking bench for jtag_dr_bridge
// Reference model treats each access as a bit stream: captured word followed by shifted-in bits.
module tb_jtag_dr_bridge;
    localparam int DW   = 32;
    localparam int NCH  = 2;
    localparam int SELW = 1;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rstn, jtck, jtdi, jshift, jupdate, jrstn, dr_ready, ovr_clr;
    logic [NCH-1:0]    jce, jtdo;
    logic [NCH*DW-1:0] dr_in;
    logic [DW-1:0]     dr_out;
    logic [SELW-1:0]   dr_sel;
    logic dr_valid, dr_short, dr_overrun;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_out;
    int exp_sel;
    bit exp_valid, exp_short, exp_ovr;

    always #5 clk = ~clk;

    jtag_dr_bridge #(.DR_WIDTH(DW), .NUM_CH(NCH), .SYNC_STAGES(2)) dut (
        .clk(clk), .rstn(rstn), .jtck(jtck), .jtdi(jtdi), .jshift(jshift),
        .jupdate(jupdate), .jce(jce), .jrstn(jrstn), .jtdo(jtdo), .dr_in(dr_in),
        .dr_out(dr_out), .dr_sel(dr_sel), .dr_valid(dr_valid), .dr_ready(dr_ready),
        .dr_short(dr_short), .dr_overrun(dr_overrun), .ovr_clr(ovr_clr)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tck_pulse();
        jtck = 1'b1;
        wait_clks(HALF);
        jtck = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".valid"}, 64'(dr_valid), 64'(exp_valid));
        chk({tag, ".out"}, 64'(dr_out), 64'(exp_out));
        chk({tag, ".sel"}, 64'(dr_sel), 64'(exp_sel));
        chk({tag, ".short"}, 64'(dr_short), 64'(exp_short));
        chk({tag, ".ovr"}, 64'(dr_overrun), 64'(exp_ovr));
    endtask

    task automatic jtag_access(input logic [NCH-1:0] mask, input int nbits,
                               input logic [63:0] din, input bit upd, input string tag);
        logic [127:0] full;
        logic [63:0]  dmask, tdo_seen;
        logic [NCH-1:0] others_mask;
        logic others;
        int ch;
        ch = 0;
        while (ch < NCH - 1 && !mask[ch]) ch++;
        others_mask = ~(NCH'(1) << ch);
        dmask = (64'd1 << nbits) - 64'd1;
        full = (128'(din & dmask) << DW) | 128'(dr_in[ch*DW +: DW]);
        tdo_seen = '0;
        others = 1'b0;
        jce = mask;
        jshift = 1'b1;
        tck_pulse();
        for (int i = 0; i < nbits; i++) begin
            jtdi = din[i];
            jshift = (i != nbits - 1);
            if (i == nbits / 2) dr_in = {$urandom, $urandom};
            tdo_seen[i] = jtdo[ch];
            others = others | (|(jtdo & others_mask));
            tck_pulse();
        end
        chk({tag, ".tdo"}, tdo_seen, full[63:0] & dmask);
        chk({tag, ".tdo_other"}, 64'(others), 64'd0);
        if (upd) begin
            jupdate = 1'b1;
            jce = '0;
            jshift = 1'b0;
            tck_pulse();
            jupdate = 1'b0;
            if (exp_valid) exp_ovr = 1'b1;
            exp_valid = 1'b1;
            exp_out = full[nbits +: DW];
            exp_sel = ch;
            exp_short = (nbits != DW);
            check_state(tag);
        end
    endtask

    task automatic consume(input string tag);
        dr_ready = 1'b1;
        wait_clks(1);
        dr_ready = 1'b0;
        exp_valid = 1'b0;
        wait_clks(1);
        chk({tag, ".consumed"}, 64'(dr_valid), 64'd0);
    endtask

    task automatic clear_ovr(input string tag);
        ovr_clr = 1'b1;
        wait_clks(1);
        ovr_clr = 1'b0;
        exp_ovr = 1'b0;
        wait_clks(1);
        chk({tag, ".ovr_clr"}, 64'(dr_overrun), 64'd0);
    endtask

    task automatic model_reset();
        exp_out = '0; exp_sel = 0; exp_valid = 0; exp_short = 0; exp_ovr = 0;
    endtask

    initial begin
        logic [DW-1:0] w2, w3;
        int n;
        rstn = 1'b0; jtck = 0; jtdi = 0; jshift = 0; jupdate = 0; jce = '0;
        jrstn = 1'b1; dr_ready = 0; ovr_clr = 0; dr_in = '0;
        model_reset();
        wait_clks(4);
        check_state("reset");
        chk("reset.jtdo", 64'(jtdo), 64'd0);
        rstn = 1'b1;
        wait_clks(10);
        check_state("idle");

        jtag_access(2'b01, 32, 64'hDEADBEEF, 1, "wr_ch0");
        consume("wr_ch0");

        dr_in = {32'h12345678, $urandom};
        jtag_access(2'b10, 32, 64'd0, 1, "rd_ch1");
        consume("rd_ch1");

        dr_in = '0;
        jtag_access(2'b01, 16, 64'hA5A5, 1, "short16");
        consume("short16");
        jtag_access(2'b11, 40, {$urandom, $urandom}, 1, "long40");
        consume("long40");

        jtag_access(2'b01, 32, 64'($urandom), 1, "ovr1");
        w2 = $urandom;
        jtag_access(2'b01, 32, 64'(w2), 1, "ovr2");
        clear_ovr("ovr2");
        w3 = ~w2;
        ovr_clr = 1'b1;
        fork
            jtag_access(2'b01, 32, 64'(w3), 1, "ovr3");
            begin
                for (n = 0; n < 3000 && dr_out !== w3; n++) @(negedge clk);
                ovr_clr = 1'b0;
                chk("ovr3.commit_seen", 64'(dr_out), 64'(w3));
            end
        join
        chk("ovr3.sticky", 64'(dr_overrun), 64'd1);
        consume("ovr3");
        clear_ovr("ovr3");

        jtag_access(2'b01, 10, {$urandom, $urandom}, 0, "tap");
        jrstn = 1'b0; jce = '0; jshift = 1'b0;
        wait_clks(6);
        chk("tap.jtdo", 64'(jtdo), 64'd0);
        rstn = rstn;
        jrstn = 1'b1;
        wait_clks(6);
        jupdate = 1'b1;
        tck_pulse();
        jupdate = 1'b0;
        check_state("tap.noupd");
        jtag_access(2'b01, 32, 64'($urandom), 1, "tap.after");
        consume("tap.after");

        for (int it = 0; it < 24; it++) begin
            logic [NCH-1:0] m;
            int nb;
            m = NCH'($urandom_range(1, 3));
            nb = ($urandom_range(0, 1) != 0) ? DW : int'($urandom_range(1, 63));
            dr_in = {$urandom, $urandom};
            jtag_access(m, nb, {$urandom, $urandom}, 1, "rand");
            if ($urandom_range(0, 1) != 0) consume("rand");
            if ($urandom_range(0, 3) == 0) clear_ovr("rand");
        end

        jtag_access(2'b01, 32, 64'($urandom), 1, "pre_rst_a");
        jtag_access(2'b10, 20, 64'($urandom), 1, "pre_rst_b");
        jtag_access(2'b01, 12, 64'($urandom), 0, "rst_mid");
        #3 rstn = 1'b0;
        #1;
        model_reset();
        check_state("async_rst");
        chk("async_rst.jtdo", 64'(jtdo), 64'd0);
        jce = '0; jshift = 1'b0;
        wait_clks(2);
        rstn = 1'b1;
        wait_clks(20);
        check_state("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
